// File: rtl/riscv_pkg.sv
// Shared datapath definitions: ULA op codes used by the control unit and
// the divider, plus the divider FSM state encoding.
package riscv_pkg;

    localparam logic [3:0] ULA_DIV = 4'b1100;
    localparam logic [3:0] ULA_REM = 4'b1110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left by one,
// try subtracting the divisor, keep the difference when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;

    // Trial subtraction on a widened copy so the sign of the result is explicit.
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        trial_s   = shifted_s - {2'b00, divisor};
        if (trial_s[WIDTH+1] == 1'b0) begin
            rem_next = trial_s[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_rem_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit. Stalls the datapath while a division
// runs; divide-by-zero and signed overflow finish in a single cycle.
module div_rem_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ULAControl,
    input  logic             UnSig,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Stall
);

    localparam int CW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    div_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             op_rem_q, op_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             valid_op_s;
    logic             a_neg_s, b_neg_s;
    logic             div_zero_s, overflow_s;
    logic [WIDTH:0]   step_rem_s;
    logic [WIDTH-1:0] step_quo_s;

    assign valid_op_s = (ULAControl == ULA_DIV) || (ULAControl == ULA_REM);
    assign a_neg_s    = ~UnSig & SrcA[WIDTH-1];
    assign b_neg_s    = ~UnSig & SrcB[WIDTH-1];
    assign div_zero_s = (SrcB == {WIDTH{1'b0}});
    assign overflow_s = ~UnSig && (SrcA == {1'b1, {(WIDTH-1){1'b0}}})
                               && (SrcB == {WIDTH{1'b1}});

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem_s),
        .quo_next (step_quo_s)
    );

    // Next-state and datapath updates for the divider FSM.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        op_rem_d  = op_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && valid_op_s) begin
                    op_rem_d = (ULAControl == ULA_REM);
                    if (div_zero_s) begin
                        result_d = (ULAControl == ULA_REM) ? SrcA : {WIDTH{1'b1}};
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (overflow_s) begin
                        result_d = (ULAControl == ULA_REM) ? {WIDTH{1'b0}} : SrcA;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        rem_d     = {(WIDTH+1){1'b0}};
                        quo_d     = a_neg_s ? twos_neg(SrcA) : SrcA;
                        dvs_d     = b_neg_s ? twos_neg(SrcB) : SrcB;
                        count_d   = {CW{1'b0}};
                        neg_quo_d = a_neg_s ^ b_neg_s;
                        neg_rem_d = a_neg_s;
                        state_d   = DIVIDE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                rem_d   = step_rem_s;
                quo_d   = step_quo_s;
                count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end else begin
                    state_d = DIVIDE;
                end
            end
            FIX: begin
                if (op_rem_q) begin
                    result_d = neg_rem_q ? twos_neg(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
                end else begin
                    result_d = neg_quo_q ? twos_neg(quo_q) : quo_q;
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == DIVIDE) || (state_d == FIX);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= {CW{1'b0}};
            rem_q     <= {(WIDTH+1){1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= {WIDTH{1'b0}};
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            op_rem_q  <= op_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;
    assign Stall  = start & valid_op_s & ~done_q;

endmodule
